// File: rtl/z80bus_pkg.sv
// Shared definitions for Z80 system-bus responders: FSM state type,
// counter width and default access timing.
package z80bus_pkg;

  localparam int unsigned SRAM_CNT_W = 4;

  localparam int unsigned DEF_RD_WAIT  = 2;
  localparam int unsigned DEF_WR_SETUP = 1;
  localparam int unsigned DEF_WR_PULSE = 2;
  localparam int unsigned DEF_WR_HOLD  = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WR_SETUP,
    ST_WR_PULSE,
    ST_WR_HOLD,
    ST_ACK
  } sram_state_t;

  // Counter preload for a phase lasting 'cycles' clocks; the phase ends on cnt==0.
  function automatic logic [SRAM_CNT_W-1:0] cnt_load(input int unsigned cycles);
    int unsigned v;
    v = cycles - 1;
    return v[SRAM_CNT_W-1:0];
  endfunction

endpackage

// File: rtl/sram_responder.sv
// System-bus responder driving an external 8-bit asynchronous SRAM with
// parameterised read-wait and write setup/pulse/hold timing.
module sram_responder
  import z80bus_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned RD_WAIT    = DEF_RD_WAIT,
  parameter int unsigned WR_SETUP   = DEF_WR_SETUP,
  parameter int unsigned WR_PULSE   = DEF_WR_PULSE,
  parameter int unsigned WR_HOLD    = DEF_WR_HOLD
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [7:0]            i_dat,
  output logic [7:0]            o_dat,
  input  logic                  i_we,
  input  logic                  i_cs,
  output logic                  o_ack,
  output logic [ADDR_WIDTH-1:0] o_sram_addr,
  output logic [7:0]            o_sram_dat,
  input  logic [7:0]            i_sram_dat,
  output logic                  o_sram_dat_oe,
  output logic                  o_sram_ce_n,
  output logic                  o_sram_oe_n,
  output logic                  o_sram_we_n
);

  localparam logic [SRAM_CNT_W-1:0] RD_LOAD    = cnt_load(RD_WAIT);
  localparam logic [SRAM_CNT_W-1:0] SETUP_LOAD = cnt_load(WR_SETUP);
  localparam logic [SRAM_CNT_W-1:0] PULSE_LOAD = cnt_load(WR_PULSE);
  localparam logic [SRAM_CNT_W-1:0] HOLD_LOAD  = cnt_load(WR_HOLD);

  sram_state_t           state;
  logic [SRAM_CNT_W-1:0] cnt;

  // Strobes are set on the transition into each state, so every output is
  // registered and reflects the state being entered in the following cycle.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      o_ack         <= 1'b0;
      o_dat         <= '0;
      o_sram_addr   <= '0;
      o_sram_dat    <= '0;
      o_sram_dat_oe <= 1'b0;
      o_sram_ce_n   <= 1'b1;
      o_sram_oe_n   <= 1'b1;
      o_sram_we_n   <= 1'b1;
    end else begin
      o_ack <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (i_cs) begin
            o_sram_addr <= i_addr;
            o_sram_dat  <= i_dat;
            o_sram_ce_n <= 1'b0;
            if (i_we) begin
              state         <= ST_WR_SETUP;
              cnt           <= SETUP_LOAD;
              o_sram_dat_oe <= 1'b1;
            end else begin
              state       <= ST_RD;
              cnt         <= RD_LOAD;
              o_sram_oe_n <= 1'b0;
            end
          end
        end

        ST_RD: begin
          if (cnt == '0) begin
            o_dat       <= i_sram_dat;
            state       <= ST_ACK;
            o_ack       <= 1'b1;
            o_sram_ce_n <= 1'b1;
            o_sram_oe_n <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        ST_WR_SETUP: begin
          if (cnt == '0) begin
            state       <= ST_WR_PULSE;
            cnt         <= PULSE_LOAD;
            o_sram_we_n <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        ST_WR_PULSE: begin
          if (cnt == '0) begin
            o_sram_we_n <= 1'b1;
            if (WR_HOLD > 0) begin
              state <= ST_WR_HOLD;
              cnt   <= HOLD_LOAD;
            end else begin
              state         <= ST_ACK;
              o_ack         <= 1'b1;
              o_sram_ce_n   <= 1'b1;
              o_sram_dat_oe <= 1'b0;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        ST_WR_HOLD: begin
          if (cnt == '0) begin
            state         <= ST_ACK;
            o_ack         <= 1'b1;
            o_sram_ce_n   <= 1'b1;
            o_sram_dat_oe <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        ST_ACK: begin
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
